// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : rotating-priority grant of up to WAYS completions onto a registered CDB
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter #(
  parameter int WAYS  = 3,
  parameter int N_REQ = 5,
  parameter int XLEN  = 32,
  parameter int PRF   = 64,
  parameter int ROB   = 16
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   squash,
  input  logic [N_REQ-1:0]                       req_valid,
  input  logic [N_REQ-1:0][XLEN-1:0]             req_data,
  input  logic [N_REQ-1:0][$clog2(PRF)-1:0]      req_PRF_idx,
  input  logic [N_REQ-1:0][$clog2(ROB)-1:0]      req_rob_idx,
  output logic [N_REQ-1:0]                       req_grant,
  output logic [WAYS-1:0]                        CDB_valid,
  output logic [WAYS-1:0][XLEN-1:0]              CDB_Data,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]       CDB_PRF_idx,
  output logic [WAYS-1:0][$clog2(ROB)-1:0]       CDB_rob_idx,
  output logic [$clog2(WAYS+1)-1:0]              num_granted
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(WAYS + 1);
  localparam int TAG_W = $clog2(PRF);
  localparam int ROB_W = $clog2(ROB);

  logic [PTR_W-1:0]            rr_ptr;
  logic [PTR_W-1:0]            rr_ptr_next;
  logic [PTR_W-1:0]            scan_ptr;
  logic [PTR_W-1:0]            last_grant;
  logic [CNT_W-1:0]            grant_cnt;
  logic [N_REQ-1:0]            grant;
  logic [PTR_W-1:0]            lane_src [WAYS];
  logic [WAYS-1:0]             lane_used;
  logic [WAYS-1:0][XLEN-1:0]   lane_data;
  logic [WAYS-1:0][TAG_W-1:0]  lane_tag;
  logic [WAYS-1:0][ROB_W-1:0]  lane_rob;

  // Walk requesters from rr_ptr with wrap; the k-th hit is packed into lane k.
  always_comb begin
    grant      = '0;
    grant_cnt  = '0;
    last_grant = '0;
    lane_used  = '0;
    scan_ptr   = '0;
    for (int w = 0; w < WAYS; w++) begin
      lane_src[w] = '0;
    end
    if (!reset && !squash) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_ptr = PTR_W'((int'(rr_ptr) + k) % N_REQ);
        if (req_valid[scan_ptr] && (grant_cnt < CNT_W'(WAYS))) begin
          grant[scan_ptr] = 1'b1;
          for (int w = 0; w < WAYS; w++) begin
            if (CNT_W'(w) == grant_cnt) begin
              lane_src[w]  = scan_ptr;
              lane_used[w] = 1'b1;
            end
          end
          last_grant = scan_ptr;
          grant_cnt  = grant_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (grant_cnt != '0) begin
      rr_ptr_next = (last_grant == PTR_W'(N_REQ - 1)) ? '0 : last_grant + PTR_W'(1);
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_lane
    assign lane_data[w] = lane_used[w] ? req_data[lane_src[w]]    : '0;
    assign lane_tag[w]  = lane_used[w] ? req_PRF_idx[lane_src[w]] : '0;
    assign lane_rob[w]  = lane_used[w] ? req_rob_idx[lane_src[w]] : '0;
  end

  // Output lanes reload every cycle so each grant is visible for exactly one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      CDB_valid   <= '0;
      CDB_Data    <= '0;
      CDB_PRF_idx <= '0;
      CDB_rob_idx <= '0;
      rr_ptr      <= '0;
    end else if (squash) begin
      CDB_valid   <= '0;
      CDB_Data    <= '0;
      CDB_PRF_idx <= '0;
      CDB_rob_idx <= '0;
      rr_ptr      <= '0;
    end else begin
      CDB_valid   <= lane_used;
      CDB_Data    <= lane_data;
      CDB_PRF_idx <= lane_tag;
      CDB_rob_idx <= lane_rob;
      rr_ptr      <= rr_ptr_next;
    end
  end

  assign req_grant   = grant;
  assign num_granted = grant_cnt;

`ifndef SYNTHESIS
  logic dup_tag;

  always_comb begin
    dup_tag = 1'b0;
    for (int a = 0; a < N_REQ; a++) begin
      for (int b = a + 1; b < N_REQ; b++) begin
        if (req_valid[a] && req_valid[b] && (req_PRF_idx[a] == req_PRF_idx[b])) begin
          dup_tag = 1'b1;
        end
      end
    end
  end

  a_no_dup_tag: assert property (@(posedge clock) disable iff (reset) !dup_tag);
  a_grant_needs_valid: assert property (@(posedge clock) disable iff (reset)
                                        (grant & ~req_valid) == '0);
  a_grant_limit: assert property (@(posedge clock) disable iff (reset)
                                  grant_cnt <= CNT_W'(WAYS));
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter : directed vector table plus reset, single-requester and soak sequences
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

  localparam int WAYS = 3;
  localparam int N    = 5;
  localparam int XLEN = 32;
  localparam int TW   = 6;
  localparam int RW   = 4;
  localparam int NONE = 7;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic                       squash = 1'b0;
  logic [N-1:0]               req_valid = '0;
  logic [N-1:0][XLEN-1:0]     req_data = '0;
  logic [N-1:0][TW-1:0]       req_tag = '0;
  logic [N-1:0][RW-1:0]       req_rob = '0;
  logic [N-1:0]               req_grant;
  logic [WAYS-1:0]            cdb_valid;
  logic [WAYS-1:0][XLEN-1:0]  cdb_data;
  logic [WAYS-1:0][TW-1:0]    cdb_tag;
  logic [WAYS-1:0][RW-1:0]    cdb_rob;
  logic [1:0]                 num_granted;

  int n_cmp = 0;
  int n_err = 0;

  cdb_arbiter #(.WAYS(WAYS), .N_REQ(N), .XLEN(XLEN), .PRF(64), .ROB(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_PRF_idx (req_tag),
    .req_rob_idx (req_rob),
    .req_grant   (req_grant),
    .CDB_valid   (cdb_valid),
    .CDB_Data    (cdb_data),
    .CDB_PRF_idx (cdb_tag),
    .CDB_rob_idx (cdb_rob),
    .num_granted (num_granted)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pdata(input int v, input int i);
    return 32'hA000_0000 + 32'(v * 256 + i);
  endfunction
  function automatic logic [TW-1:0] ptag(input int v, input int i);
    return TW'(i * 10 + v % 10);
  endfunction
  function automatic logic [RW-1:0] prob(input int v, input int i);
    return RW'((i + v) % 16);
  endfunction

  task automatic set_payload(input int v);
    for (int i = 0; i < N; i++) begin
      req_data[i] = pdata(v, i);
      req_tag[i]  = ptag(v, i);
      req_rob[i]  = prob(v, i);
    end
  endtask

  typedef struct {
    logic       sq;
    logic [4:0] valid;
    logic [4:0] grant;
    int         num;
    logic [2:0] cdbv;
    int         s0;
    int         s1;
    int         s2;
    int         ptr;
  } vec_t;

  vec_t vecs [13];

  // soak state
  logic [N-1:0] pend;
  int           age [N];
  int           m_ptr;
  logic [N-1:0] eg;
  int           ecnt;
  int           elast;
  int           esrc [WAYS];
  int           max_age;

  initial begin
    vecs[0]  = '{1'b0, 5'b11111, 5'b00111, 3, 3'b111, 0, 1, 2, 3};
    vecs[1]  = '{1'b0, 5'b11111, 5'b11001, 3, 3'b111, 3, 4, 0, 1};
    vecs[2]  = '{1'b0, 5'b00000, 5'b00000, 0, 3'b000, NONE, NONE, NONE, 1};
    vecs[3]  = '{1'b0, 5'b00100, 5'b00100, 1, 3'b001, 2, NONE, NONE, 3};
    vecs[4]  = '{1'b0, 5'b01010, 5'b01010, 2, 3'b011, 3, 1, NONE, 2};
    vecs[5]  = '{1'b0, 5'b10000, 5'b10000, 1, 3'b001, 4, NONE, NONE, 0};
    vecs[6]  = '{1'b0, 5'b00111, 5'b00111, 3, 3'b111, 0, 1, 2, 3};
    vecs[7]  = '{1'b1, 5'b11111, 5'b00000, 0, 3'b000, NONE, NONE, NONE, 0};
    vecs[8]  = '{1'b0, 5'b11111, 5'b00111, 3, 3'b111, 0, 1, 2, 3};
    vecs[9]  = '{1'b0, 5'b11111, 5'b11001, 3, 3'b111, 3, 4, 0, 1};
    vecs[10] = '{1'b0, 5'b11110, 5'b01110, 3, 3'b111, 1, 2, 3, 4};
    vecs[11] = '{1'b0, 5'b01111, 5'b00111, 3, 3'b111, 0, 1, 2, 3};
    vecs[12] = '{1'b0, 5'b00011, 5'b00011, 2, 3'b011, 0, 1, NONE, 2};

    // Reset held with requests pending: nothing granted, CDB cleared.
    req_valid = 5'b11111;
    set_payload(15);
    repeat (2) @(posedge clock);
    #1;
    check("rst_grant", req_grant, 0);
    check("rst_num", num_granted, 0);
    check("rst_cdbv", cdb_valid, 0);
    check("rst_ptr", dut.rr_ptr, 0);
    reset = 1'b0;
    #3;
    check("post_rst_grant", req_grant, 5'b00111);
    @(posedge clock);
    #1;
    check("post_rst_cdbv", cdb_valid, 3'b111);
    check("post_rst_lane0", cdb_data[0], pdata(15, 0));
    // Asynchronous reset pulse between edges.
    reset = 1'b1;
    #1;
    check("arst_cdbv", cdb_valid, 0);
    check("arst_data0", cdb_data[0], 0);
    check("arst_tag0", cdb_tag[0], 0);
    check("arst_grant", req_grant, 0);
    check("arst_num", num_granted, 0);
    check("arst_ptr", dut.rr_ptr, 0);
    reset = 1'b0;
    #1;

    for (int v = 0; v < 13; v++) begin
      int src [WAYS];
      req_valid = vecs[v].valid;
      squash    = vecs[v].sq;
      set_payload(v);
      #3;
      check($sformatf("v%0d_grant", v), req_grant, vecs[v].grant);
      check($sformatf("v%0d_num", v), num_granted, vecs[v].num);
      @(posedge clock);
      #1;
      src[0] = vecs[v].s0;
      src[1] = vecs[v].s1;
      src[2] = vecs[v].s2;
      check($sformatf("v%0d_cdbv", v), cdb_valid, vecs[v].cdbv);
      for (int w = 0; w < WAYS; w++) begin
        check($sformatf("v%0d_data%0d", v, w), cdb_data[w], (src[w] == NONE) ? 0 : pdata(v, src[w]));
        check($sformatf("v%0d_tag%0d", v, w), cdb_tag[w], (src[w] == NONE) ? 0 : ptag(v, src[w]));
        check($sformatf("v%0d_rob%0d", v, w), cdb_rob[w], (src[w] == NONE) ? 0 : prob(v, src[w]));
      end
      check($sformatf("v%0d_ptr", v), dut.rr_ptr, vecs[v].ptr);
    end
    squash = 1'b0;

    // Bring pointer to 0, then a lone req4 must wrap the pointer back to 0.
    req_valid = 5'b10000;
    set_payload(20);
    @(posedge clock);
    #1;
    check("single_pre_ptr", dut.rr_ptr, 0);
    req_data[4] = 32'hDEADBEEF;
    req_tag[4]  = 6'd37;
    req_rob[4]  = 4'd5;
    #2;
    check("single_grant", req_grant, 5'b10000);
    check("single_num", num_granted, 1);
    @(posedge clock);
    #1;
    check("single_cdbv", cdb_valid, 3'b001);
    check("single_data", cdb_data[0], 32'hDEADBEEF);
    check("single_tag", cdb_tag[0], 37);
    check("single_rob", cdb_rob[0], 5);
    check("single_lane1", cdb_data[1], 0);
    check("single_ptr", dut.rr_ptr, 0);

    // Soak: random requests held until granted.
    req_valid = '0;
    pend  = '0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) age[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]     = 1'b1;
          age[i]      = 0;
          req_data[i] = $urandom;
          req_tag[i]  = TW'(i * 12 + int'($urandom_range(0, 11)));
          req_rob[i]  = RW'($urandom_range(0, 15));
        end
      end
      req_valid = pend;
      #3;
      eg    = '0;
      ecnt  = 0;
      elast = 0;
      for (int w = 0; w < WAYS; w++) esrc[w] = NONE;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (pend[idx] && ecnt < WAYS) begin
          eg[idx]    = 1'b1;
          esrc[ecnt] = idx;
          ecnt++;
          elast = idx;
        end
      end
      if (ecnt > 0) m_ptr = (elast + 1) % N;
      check("soak_grant", req_grant, eg);
      check("soak_num", num_granted, ecnt);
      @(posedge clock);
      #1;
      for (int w = 0; w < WAYS; w++) begin
        check("soak_lanev", cdb_valid[w], esrc[w] != NONE);
        check("soak_data", cdb_data[w], (esrc[w] == NONE) ? 0 : req_data[esrc[w]]);
        check("soak_tag", cdb_tag[w], (esrc[w] == NONE) ? 0 : req_tag[esrc[w]]);
        check("soak_rob", cdb_rob[w], (esrc[w] == NONE) ? 0 : req_rob[esrc[w]]);
      end
      check("soak_ptr", dut.rr_ptr, m_ptr);
      max_age = 0;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if (eg[i]) begin
            pend[i] = 1'b0;
          end else begin
            age[i]++;
            if (age[i] > max_age) max_age = age[i];
          end
        end
      end
      n_cmp++;
      if (max_age >= 2) begin
        n_err++;
        $display("FAIL soak_fairness: waited %0d cycles, limit 1 ungranted cycle", max_age);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the `WAYS` common data bus (CDB) lanes among the functional-unit completion ports. Up to `N_REQ` units (ALUs, multiplier, load unit) present results each cycle. A rotating-priority scheduler grants up to `WAYS` of them per cycle and drives the granted results onto a registered CDB. The RS lines, the RS dispatch-time bypass and the ROB consume that CDB (`CDB_valid`, `CDB_Data`, `CDB_PRF_idx`).

## Interface
- `WAYS`, 3, number of CDB lanes
- `N_REQ`, 5, number of completion requesters; must be ≥ `WAYS`
- `XLEN`, 32, result width
- `PRF`, 64, physical registers; index width `$clog2(PRF)`
- `ROB`, 16, ROB entries; index width `$clog2(ROB)`

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `squash`  in  1  synchronous flush (branch mispredict)
- `req_valid`  in  N_REQ  requester i holds a completed result
- `req_data`  in  N_REQ×XLEN  result value
- `req_PRF_idx`  in  N_REQ×$clog2(PRF)  destination physical register
- `req_rob_idx`  in  N_REQ×$clog2(ROB)  ROB entry to mark complete
- `req_grant`  out  N_REQ  combinational; result i is accepted this cycle
- `CDB_valid`  out  WAYS  registered lane valid
- `CDB_Data`  out  WAYS×XLEN  registered lane data
- `CDB_PRF_idx`  out  WAYS×$clog2(PRF)  registered lane tag
- `CDB_rob_idx`  out  WAYS×$clog2(ROB)  registered lane ROB index
- `num_granted`  out  $clog2(WAYS+1)  combinational count of grants this cycle

## Operation
- **Handshake.** A transfer occurs when `req_valid[i] & req_grant[i]` at a rising edge.
  - Requesters hold `valid` and payload stable until granted.
  - `req_grant[i]` is never high when `req_valid[i]` is low.
- **Selection.** Scan order is `rr_ptr, rr_ptr+1, …, N_REQ-1, 0, …, rr_ptr-1`.
  - The first `WAYS` requesters with `valid` high in that order are granted.
  - The k-th granted requester in scan order drives lane k.
  - Lanes are packed from lane 0; unused upper lanes are invalid.
- **Pointer.**
  - `rr_ptr` is a `$clog2(N_REQ)`-bit register.
  - If ≥1 grant: `rr_ptr <= (index of last granted requester + 1) mod N_REQ`.
  - If no grant: `rr_ptr` holds.
- **Output register.**
  - Lanes 0..`num_granted`-1 load the granted payloads with `CDB_valid`=1.
  - Remaining lanes load `CDB_valid`=0, data/tag/rob=0.
  - The output register reloads every cycle; a lane is valid for exactly one cycle per grant.
- **Squash.**
  - `req_grant`=0 and `num_granted`=0 that cycle.
  - Next edge: `CDB_valid`=0, all lane fields 0, `rr_ptr`=0.
  - Requesters flush themselves; no result is dropped after being granted.
- **Fairness.** A requester holding `valid` is granted within `ceil(N_REQ/WAYS)` cycles, which is 2 for defaults.
- **Reset.** `reset` asynchronously forces `CDB_valid`=0, `CDB_Data`/`CDB_PRF_idx`/`CDB_rob_idx`=0 and `rr_ptr`=0.
  - While `reset` is high, `req_grant`=0 and `num_granted`=0.
  - Reset has priority over `squash`.
- **Duplicate tags.** Duplicate `req_PRF_idx` values across requesters are illegal. A simulation-only assertion flags any cycle with two valid requesters carrying the same tag.

## Timing
- Grant decision is combinational from `req_valid` and `rr_ptr`, in the same cycle.
- CDB latency is 1 cycle: a grant at edge N makes data visible on the CDB from edge N until edge N+1.
- The CDB is glitch-free: all CDB outputs come directly from flops.
- Throughput is `WAYS` results per cycle, sustained.
- Reset assertion takes effect without a clock edge. Deassertion is synchronized externally, so the first grant occurs on the first edge after deassertion.

## Test plan
- **Reset.** Drive valid payloads, then pulse `reset` between edges. Required: `CDB_valid`=000 and lane fields 0 immediately, `req_grant`=0, `rr_ptr`=0.
- **All requesters valid, `rr_ptr`=0.**
  - Cycle 0: `req_grant`=00111 and `num_granted`=3.
  - Next cycle: lanes 0/1/2 carry the req0/1/2 data, tags and rob indices; `rr_ptr`=3.
  - Cycle 1 (all still valid): grants req3, req4, req0 on lanes 0/1/2; `rr_ptr`=1.
- **Single requester.** `rr_ptr`=0, only req4 valid with data 0xDEADBEEF and tag 37. Required: lane 0 = {1, 0xDEADBEEF, 37}, `CDB_valid`=001, `rr_ptr`=0 (wrap).
- **Wrap-around.** `rr_ptr`=3, valid={1,3}. Required: req3 → lane 0, req1 → lane 1, `CDB_valid`=011, `rr_ptr`=2.
- **Squash.** All requesters valid and `squash`=1. Required: `req_grant`=0, next-cycle `CDB_valid`=000, `rr_ptr`=0. One cycle later with `squash`=0: grants 00111.
- **Fairness soak.** Random valid patterns held until granted over 10k cycles. Required: no requester waits more than 2 cycles; every granted payload appears on the CDB exactly once, one cycle later.
